// File: rtl/wire_arith_engine.sv
// -----------------------------------------------------------------------------
// wire_arith_engine
//
// Multi-channel sequenced arithmetic engine sitting between the host endpoint
// fabric and user logic, entirely in the okClk domain.
//
// A single-cycle start request latches NCH operand pairs and the operation
// mode into shadow registers, then processes one channel per clock. Each
// channel result and its overflow/underflow flag are written back in
// channel order. A one-cycle done pulse marks completion.
//
// Parameters
//   WIDTH : operand/result width in bits (2..32)
//   NCH   : number of channels (1..16)
//   SAT   : 1 = clamp on overflow/underflow, 0 = wrap modulo 2^WIDTH
//
// Ports
//   okClk    in   host interface clock, rising edge
//   reset    in   synchronous active-high reset
//   start    in   single-cycle run request
//   mode     in   0 add, 1 subtract (a-b), 2 accumulate (res += a+b), 3 clear
//   op_a     in   NCH*WIDTH packed operand A, channel k at [k*WIDTH +: WIDTH]
//   op_b     in   NCH*WIDTH packed operand B, same packing
//   result   out  NCH*WIDTH packed per-channel result
//   ovf      out  NCH per-channel overflow/underflow flag of the last run
//   busy     out  high while a run is in progress
//   done     out  one-cycle pulse at run completion
//   err_busy out  sticky flag: start arrived while busy
// -----------------------------------------------------------------------------
module wire_arith_engine #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SAT   = 0
) (
  input  logic                 okClk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [NCH*WIDTH-1:0] op_a,
  input  logic [NCH*WIDTH-1:0] op_b,
  output logic [NCH*WIDTH-1:0] result,
  output logic [NCH-1:0]       ovf,
  output logic                 busy,
  output logic                 done,
  output logic                 err_busy
);

  // Channel index width; at least one bit so NCH=1 still has a legal vector.
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  localparam logic [1:0] MODE_ADD = 2'd0;
  localparam logic [1:0] MODE_SUB = 2'd1;
  localparam logic [1:0] MODE_ACC = 2'd2;
  localparam logic [1:0] MODE_CLR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Channel arithmetic. Returns {flag, result}. Everything is unsigned and
  // carried at WIDTH+1 bits so the top bit is the carry (add/accumulate) or
  // the borrow (subtract).
  // ---------------------------------------------------------------------------
  function automatic logic [WIDTH:0] ch_compute(
    input logic [1:0]       m,
    input logic [WIDTH-1:0] prev,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH:0]   s1;
    logic [WIDTH:0]   s2;
    logic [WIDTH-1:0] res;
    logic             ov;
    s1  = {(WIDTH+1){1'b0}};
    s2  = {(WIDTH+1){1'b0}};
    res = {WIDTH{1'b0}};
    ov  = 1'b0;
    case (m)
      MODE_ADD: begin
        s1  = {1'b0, a} + {1'b0, b};
        ov  = s1[WIDTH];
        res = (ov && (SAT != 0)) ? {WIDTH{1'b1}} : s1[WIDTH-1:0];
      end
      MODE_SUB: begin
        // Borrow shows up as the top bit of the extended difference.
        s1  = {1'b0, a} - {1'b0, b};
        ov  = s1[WIDTH];
        res = (ov && (SAT != 0)) ? {WIDTH{1'b0}} : s1[WIDTH-1:0];
      end
      MODE_ACC: begin
        // Two chained additions; a carry out of either one flags overflow.
        // The wrapped value equals (prev + a + b) mod 2^WIDTH.
        s1  = {1'b0, a} + {1'b0, b};
        s2  = {1'b0, prev} + {1'b0, s1[WIDTH-1:0]};
        ov  = s1[WIDTH] | s2[WIDTH];
        res = (ov && (SAT != 0)) ? {WIDTH{1'b1}} : s2[WIDTH-1:0];
      end
      MODE_CLR: begin
        ov  = 1'b0;
        res = {WIDTH{1'b0}};
      end
      default: begin
        ov  = 1'b0;
        res = {WIDTH{1'b0}};
      end
    endcase
    return {ov, res};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [NCH*WIDTH-1:0] sh_a_q, sh_a_d;
  logic [NCH*WIDTH-1:0] sh_b_q, sh_b_d;
  logic [1:0]           sh_mode_q, sh_mode_d;
  logic [NCH*WIDTH-1:0] result_q, result_d;
  logic [NCH-1:0]       ovf_q, ovf_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  // Current channel operands and computed outcome.
  logic [WIDTH-1:0]     ch_a_s;
  logic [WIDTH-1:0]     ch_b_s;
  logic [WIDTH-1:0]     ch_prev_s;
  logic [WIDTH:0]       ch_out_s;

  // Register bank with synchronous reset; reset dominates everything.
  always_ff @(posedge okClk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= {IW{1'b0}};
      sh_a_q    <= {(NCH*WIDTH){1'b0}};
      sh_b_q    <= {(NCH*WIDTH){1'b0}};
      sh_mode_q <= 2'd0;
      result_q  <= {(NCH*WIDTH){1'b0}};
      ovf_q     <= {NCH{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sh_a_q    <= sh_a_d;
      sh_b_q    <= sh_b_d;
      sh_mode_q <= sh_mode_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Sequencer next-state: launch, channel stepping, completion.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sh_a_d    = sh_a_q;
    sh_b_d    = sh_b_q;
    sh_mode_d = sh_mode_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Snapshot inputs so later changes cannot disturb the run.
          sh_a_d    = op_a;
          sh_b_d    = op_b;
          sh_mode_d = mode;
          idx_d     = {IW{1'b0}};
          state_d   = ST_RUN;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = {IW{1'b0}};
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + {{(IW-1){1'b0}}, 1'b1};
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = {IW{1'b0}};
      end
    endcase
  end

  // Operand selection for the channel currently being processed.
  always_comb begin
    ch_a_s    = sh_a_q[32'(idx_q) * WIDTH +: WIDTH];
    ch_b_s    = sh_b_q[32'(idx_q) * WIDTH +: WIDTH];
    ch_prev_s = result_q[32'(idx_q) * WIDTH +: WIDTH];
    ch_out_s  = ch_compute(sh_mode_q, ch_prev_s, ch_a_s, ch_b_s);
  end

  // Result/flag write-back: only the active channel changes, others hold.
  always_comb begin
    result_d = result_q;
    ovf_d    = ovf_q;
    if (state_q == ST_RUN) begin
      result_d[32'(idx_q) * WIDTH +: WIDTH] = ch_out_s[WIDTH-1:0];
      ovf_d[idx_q]                          = ch_out_s[WIDTH];
    end else begin
      result_d = result_q;
      ovf_d    = ovf_q;
    end
  end

  // Status outputs, registered from the upcoming state.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // Sticky busy-collision flag; a new collision outranks a clear-run release.
  always_comb begin
    err_d = err_q;
    if (start && (state_q != ST_IDLE)) begin
      err_d = 1'b1;
    end else if ((state_q == ST_DONE) && (sh_mode_q == MODE_CLR)) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  assign result   = result_q;
  assign ovf      = ovf_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err_busy = err_q;

endmodule

// File: tb/tb_wire_arith_engine.sv
// -----------------------------------------------------------------------------
// Bench for wire_arith_engine. Two instances (wrap and saturate) share the
// same stimulus. A timing/arithmetic model derived from the run rules
// predicts every output each cycle; literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_wire_arith_engine;
  localparam int W = 32;
  localparam int N = 4;
  localparam longint unsigned MOD = 64'h1_0000_0000;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [1:0]     mode;
  logic [N*W-1:0] op_a;
  logic [N*W-1:0] op_b;
  logic [N*W-1:0] res0, res1;
  logic [N-1:0]   ovf0, ovf1;
  logic           busy0, busy1, done0, done1, err0, err1;

  always #5 clk = ~clk;

  wire_arith_engine #(.WIDTH(W), .NCH(N), .SAT(0)) u_wrap (
    .okClk(clk), .reset(reset), .start(start), .mode(mode),
    .op_a(op_a), .op_b(op_b), .result(res0), .ovf(ovf0),
    .busy(busy0), .done(done0), .err_busy(err0)
  );

  wire_arith_engine #(.WIDTH(W), .NCH(N), .SAT(1)) u_sat (
    .okClk(clk), .reset(reset), .start(start), .mode(mode),
    .op_a(op_a), .op_b(op_b), .result(res1), .ovf(ovf1),
    .busy(busy1), .done(done1), .err_busy(err1)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] p4(input logic [31:0] c3, input logic [31:0] c2,
                                      input logic [31:0] c1, input logic [31:0] c0);
    return {c3, c2, c1, c0};
  endfunction

  // ---------------- behavioural model ----------------
  longint unsigned m_res [2][N];
  bit              m_ovf [2][N];
  bit              m_busy, m_done, m_err, m_valid;
  int              m_cyc;              // -1 idle, 0..N-1 channel next, N completion cycle
  longint unsigned sh_a [N];
  longint unsigned sh_b [N];
  int              sh_mode;

  task automatic model_op(input bit sat, input int m, input longint unsigned prev,
                          input longint unsigned a, input longint unsigned b,
                          output longint unsigned r, output bit ov);
    longint unsigned s1;
    case (m)
      0: begin
        s1 = a + b;
        ov = (s1 >= MOD);
        r  = ov ? (sat ? MOD - 1 : s1 - MOD) : s1;
      end
      1: begin
        ov = (a < b);
        r  = ov ? (sat ? 64'd0 : a + MOD - b) : a - b;
      end
      2: begin
        s1 = a + b;
        ov = (s1 >= MOD) || ((prev + (s1 % MOD)) >= MOD);
        r  = (ov && sat) ? MOD - 1 : (prev + a + b) % MOD;
      end
      default: begin
        r  = 64'd0;
        ov = 1'b0;
      end
    endcase
  endtask

  function automatic logic [127:0] m_pack_res(input int s);
    logic [127:0] v;
    for (int k = 0; k < N; k++) v[k*32 +: 32] = m_res[s][k][31:0];
    return v;
  endfunction

  function automatic logic [3:0] m_pack_ovf(input int s);
    logic [3:0] v;
    for (int k = 0; k < N; k++) v[k] = m_ovf[s][k];
    return v;
  endfunction

  initial begin
    m_valid = 1'b0;
    m_cyc   = -1;
    forever begin
      @(posedge clk);
      if (reset) begin
        for (int s = 0; s < 2; s++)
          for (int k = 0; k < N; k++) begin
            m_res[s][k] = 64'd0;
            m_ovf[s][k] = 1'b0;
          end
        m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_cyc = -1; m_valid = 1'b1;
      end else if (m_cyc < 0) begin
        m_done = 1'b0;
        if (start) begin
          for (int k = 0; k < N; k++) begin
            sh_a[k] = longint'(op_a[k*32 +: 32]);
            sh_b[k] = longint'(op_b[k*32 +: 32]);
          end
          sh_mode = int'(mode);
          m_cyc   = 0;
          m_busy  = 1'b1;
        end else begin
          m_busy = 1'b0;
        end
      end else if (m_cyc < N) begin
        if (start) m_err = 1'b1;
        for (int s = 0; s < 2; s++) begin
          longint unsigned r;
          bit ov;
          model_op(bit'(s), sh_mode, m_res[s][m_cyc], sh_a[m_cyc], sh_b[m_cyc], r, ov);
          m_res[s][m_cyc] = r;
          m_ovf[s][m_cyc] = ov;
        end
        m_cyc++;
        m_done = (m_cyc == N);
        m_busy = 1'b1;
      end else begin
        if (sh_mode == 3) m_err = 1'b0;
        if (start) m_err = 1'b1;
        m_done = 1'b0;
        m_busy = 1'b0;
        m_cyc  = -1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("wrap_result", res0, m_pack_res(0));
      chk("sat_result",  res1, m_pack_res(1));
      chk("wrap_ovf",    ovf0, m_pack_ovf(0));
      chk("sat_ovf",     ovf1, m_pack_ovf(1));
      chk("wrap_busy",   busy0, m_busy);
      chk("sat_busy",    busy1, m_busy);
      chk("wrap_done",   done0, m_done);
      chk("sat_done",    done1, m_done);
      chk("wrap_err",    err0, m_err);
      chk("sat_err",     err1, m_err);
    end
  end

  initial forever begin
    @(negedge clk);
    if (done0) done_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic run_op(input logic [1:0] m, input logic [127:0] a, input logic [127:0] b,
                        input bit scramble, output int lat);
    @(posedge clk); #2;
    mode = m; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (scramble) op_a = {$urandom(), $urandom(), $urandom(), $urandom()};
    end while (!done0 && lat < 20);
    chk("done_seen", done0, 1'b1);
    @(posedge clk); #2;
  endtask

  initial begin
    int lat;
    int dc;
    reset = 1'b1; start = 1'b0; mode = 2'd0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("idle_result", res0, 128'd0);
    chk("idle_ovf",    ovf0, 4'd0);
    chk("idle_busy",   busy0, 1'b0);
    chk("idle_done",   done0, 1'b0);
    chk("idle_err",    err0, 1'b0);

    // add
    run_op(2'd0, p4(32'hFFFF_FFFF, 32'd3, 32'd2, 32'd1), p4(32'd1, 32'd30, 32'd20, 32'd10), 1'b0, lat);
    chk("add_latency", lat, 5);
    chk("add_wrap_res", res0, p4(32'd0, 32'd33, 32'd22, 32'd11));
    chk("add_wrap_ovf", ovf0, 4'b1000);
    chk("add_sat_res",  res1, p4(32'hFFFF_FFFF, 32'd33, 32'd22, 32'd11));
    chk("add_sat_ovf",  ovf1, 4'b1000);

    // subtract
    run_op(2'd1, p4(32'd7, 32'd7, 32'd0, 32'd5), p4(32'd8, 32'd7, 32'd1, 32'd3), 1'b0, lat);
    chk("sub_wrap_res", res0, p4(32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd2));
    chk("sub_sat_res",  res1, p4(32'd0, 32'd0, 32'd0, 32'd2));
    chk("sub_ovf",      ovf0, 4'b1010);

    // clear, then accumulate three times
    run_op(2'd3, '0, '0, 1'b0, lat);
    chk("clr_res", res0, 128'd0);
    for (int i = 0; i < 3; i++)
      run_op(2'd2, p4(32'h8000_0000, 32'd1, 32'd1, 32'd1), p4(32'h8000_0000, 32'd1, 32'd1, 32'd1), 1'b0, lat);
    chk("acc_wrap_res", res0, p4(32'd0, 32'd6, 32'd6, 32'd6));
    chk("acc_sat_res",  res1, p4(32'hFFFF_FFFF, 32'd6, 32'd6, 32'd6));
    chk("acc_ovf",      ovf0, 4'b1000);

    // start while busy
    dc = done_cnt;
    @(posedge clk); #2;
    mode = 2'd0; op_a = p4(32'd4, 32'd3, 32'd2, 32'd1); op_b = '0; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    @(negedge clk);
    chk("err_set", err0, 1'b1);
    repeat (10) @(posedge clk);
    #2;
    chk("single_done", done_cnt - dc, 1);
    chk("err_held", err0, 1'b1);
    run_op(2'd3, '0, '0, 1'b0, lat);
    chk("clr2_res", res0, 128'd0);
    chk("clr2_err", err0, 1'b0);

    // operands change during run
    run_op(2'd0, p4(32'd400, 32'd300, 32'd200, 32'd100), p4(32'd1, 32'd1, 32'd1, 32'd1), 1'b1, lat);
    chk("shadow_res", res0, p4(32'd401, 32'd301, 32'd201, 32'd101));

    // reset mid-run
    dc = done_cnt;
    @(posedge clk); #2;
    mode = 2'd0; op_a = p4(32'd9, 32'd9, 32'd9, 32'd9); op_b = '0; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_res",  res0, 128'd0);
    repeat (8) @(posedge clk);
    #2;
    chk("rst_no_done", done_cnt - dc, 0);

    // start held high across a whole run
    dc = done_cnt;
    @(posedge clk); #2;
    mode = 2'd0; op_a = p4(32'd1, 32'd1, 32'd1, 32'd1); op_b = p4(32'd2, 32'd2, 32'd2, 32'd2);
    start = 1'b1;
    repeat (N + 3) @(posedge clk);
    #2 start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("held_two_runs", done_cnt - dc, 2);
    chk("held_err", err0, 1'b1);
    chk("held_res", res0, p4(32'd3, 32'd3, 32'd3, 32'd3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
